// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the operand-read stage and the multiply/divide unit.
// The master drives the issue fields; the slave returns status and HI/LO.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU are ignored.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst_n,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic               neg_lo;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               mul_go;
    logic               mthi_go;
    logic               mtlo_go;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_nx;
    logic [2*WIDTH-1:0] prod;

`ifdef MDU_DIV_EN
    logic               is_div;
    logic               neg_hi;
    logic [WIDTH-1:0]   araw;
    logic               dz_q;
    logic               div_go;
    logic [WIDTH:0]     rsh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_nx;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
`endif

    // Signed ops run on magnitudes; signs are restored in FIX.
    always_comb begin
        sgn     = ~bus.op[0];
        a_neg   = sgn & bus.a[WIDTH-1];
        b_neg   = sgn & bus.b[WIDTH-1];
        a_abs   = a_neg ? -bus.a : bus.a;
        b_abs   = b_neg ? -bus.b : bus.b;
        mul_go  = bus.start & (bus.op[2:1] == 2'b00);
        mthi_go = bus.start & (bus.op == 3'b100);
        mtlo_go = bus.start & (bus.op == 3'b101);
    end

    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        mul_nx = acc[0] ? {sum, acc[WIDTH-1:1]}
                        : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
        prod   = neg_lo ? -acc : acc;
    end

`ifdef MDU_DIV_EN
    always_comb begin
        div_go = bus.start & (bus.op[2:1] == 2'b01);
        rsh    = acc[2*WIDTH-1:WIDTH-1];
        diff   = rsh - {1'b0, mcand};
        div_nx = diff[WIDTH] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        quo    = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            neg_lo <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef MDU_DIV_EN
            is_div <= 1'b0;
            neg_hi <= 1'b0;
            araw   <= '0;
            dz_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MDU_DIV_EN
            dz_q   <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        mul_go: begin
                            state  <= RUN;
                            cnt    <= CNT_TOP;
                            acc    <= {{WIDTH{1'b0}}, b_abs};
                            mcand  <= a_abs;
                            neg_lo <= a_neg ^ b_neg;
                            busy_q <= 1'b1;
`ifdef MDU_DIV_EN
                            is_div <= 1'b0;
                            neg_hi <= a_neg;
`endif
                        end
`ifdef MDU_DIV_EN
                        div_go: begin
                            state  <= RUN;
                            cnt    <= CNT_TOP;
                            acc    <= {{WIDTH{1'b0}}, a_abs};
                            mcand  <= b_abs;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg;
                            araw   <= bus.a;
                            is_div <= 1'b1;
                            busy_q <= 1'b1;
                        end
`endif
                        mthi_go: hi_q <= bus.a;
                        mtlo_go: lo_q <= bus.a;
                        default: ;
                    endcase
                end
                RUN: begin
`ifdef MDU_DIV_EN
                    acc <= is_div ? div_nx : mul_nx;
`else
                    acc <= mul_nx;
`endif
                    if (cnt == '0) state <= FIX;
                    else cnt <= cnt - CW'(1);
                end
                FIX: begin
`ifdef MDU_DIV_EN
                    if (is_div && mcand == '0) begin
                        // Divide by zero reports the raw dividend, unsigned-style.
                        lo_q <= '1;
                        hi_q <= araw;
                        dz_q <= 1'b1;
                    end else if (is_div) begin
                        lo_q <= quo;
                        hi_q <= rem;
                    end else begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end
`else
                    hi_q <= prod[2*WIDTH-1:WIDTH];
                    lo_q <= prod[WIDTH-1:0];
`endif
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`ifdef MDU_DIV_EN
    assign bus.div_zero = dz_q;
`else
    assign bus.div_zero = 1'b0;
`endif
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit; divide checks follow MDU_DIV_EN.
// Outputs are sampled on the falling edge, inputs change on the falling edge.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    // Issue one op and return at the falling edge where done is seen.
    // lat counts sampled busy cycles; -1 means done never arrived.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat,
                          output logic dz);
        bit seen;
        lat = 0;
        dz = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                dz = bus.div_zero;
            end else begin
                if (bus.busy === 1'b1) lat++;
                @(negedge clk);
            end
        end
        if (!seen) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.hi !== 32'h0) begin
            errs++;
            $display("FAIL reset_hi: got %h want %h", bus.hi, 32'h0);
        end
        checks++;
        if (bus.lo !== 32'h0) begin
            errs++;
            $display("FAIL reset_lo: got %h want %h", bus.lo, 32'h0);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errs++;
            $display("FAIL reset_done: got %b want 0", bus.done);
        end
        checks++;
        if (bus.div_zero !== 1'b0) begin
            errs++;
            $display("FAIL reset_dz: got %b want 0", bus.div_zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_multu();
        int lat;
        logic dz;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, dz);
        checks++;
        if (lat !== 33) begin
            errs++;
            $display("FAIL multu_latency: got %0d want 33", lat);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL multu_busy_at_done: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.hi !== 32'hFFFF_FFFE) begin
            errs++;
            $display("FAIL multu_hi: got %h want %h", bus.hi, 32'hFFFF_FFFE);
        end
        checks++;
        if (bus.lo !== 32'h0000_0001) begin
            errs++;
            $display("FAIL multu_lo: got %h want %h", bus.lo, 32'h1);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errs++;
            $display("FAIL multu_done_pulse: got %b want 0", bus.done);
        end
    endtask

    task automatic test_mult();
        int lat;
        logic dz;
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, lat, dz);
        checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            errs++;
            $display("FAIL mult_neg: got %h_%h want FFFFFFFF_FFFFFFFA",
                     bus.hi, bus.lo);
        end
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFC, lat, dz);
        checks++;
        if ({bus.hi, bus.lo} !== 64'd12) begin
            errs++;
            $display("FAIL mult_negneg: got %h_%h want 0_C", bus.hi, bus.lo);
        end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        int lat;
        logic dz;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, dz);
        checks++;
        if (lat !== 33) begin
            errs++;
            $display("FAIL div_latency: got %0d want 33", lat);
        end
        checks++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            errs++;
            $display("FAIL div_neg: got hi=%h lo=%h want FFFFFFFF FFFFFFFD",
                     bus.hi, bus.lo);
        end
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, dz);
        checks++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'd1) begin
            errs++;
            $display("FAIL div_negdivisor: got hi=%h lo=%h want 1 FFFFFFFD",
                     bus.hi, bus.lo);
        end
        run_op(OP_DIVU, 32'd100, 32'd7, lat, dz);
        checks++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            errs++;
            $display("FAIL divu: got hi=%h lo=%h want 2 E", bus.hi, bus.lo);
        end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, dz);
        checks++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
            errs++;
            $display("FAIL div_overflow: got hi=%h lo=%h want 0 80000000",
                     bus.hi, bus.lo);
        end
    endtask
`endif

    task automatic test_div_zero();
        int lat;
        logic dz;
        logic [31:0] hi0;
        logic [31:0] lo0;
        int nbusy;
        hi0 = bus.hi;
        lo0 = bus.lo;
`ifdef MDU_DIV_EN
        run_op(OP_DIVU, 32'h64, 32'd0, lat, dz);
        checks++;
        if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h64) begin
            errs++;
            $display("FAIL divzero_result: got hi=%h lo=%h want 64 FFFFFFFF",
                     bus.hi, bus.lo);
        end
        checks++;
        if (dz !== 1'b1) begin
            errs++;
            $display("FAIL divzero_flag: got %b want 1", dz);
        end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, lat, dz);
        checks++;
        if (bus.hi !== 32'hFFFF_FFF9 || dz !== 1'b1) begin
            errs++;
            $display("FAIL divzero_signed: got hi=%h dz=%b want FFFFFFF9 1",
                     bus.hi, dz);
        end
        @(negedge clk);
        checks++;
        if (bus.div_zero !== 1'b0) begin
            errs++;
            $display("FAIL divzero_pulse: got %b want 0", bus.div_zero);
        end
`else
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = OP_DIVU;
        bus.a = 32'h64;
        bus.b = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) nbusy++;
            @(negedge clk);
        end
        checks++;
        if (nbusy !== 0) begin
            errs++;
            $display("FAIL nodiv_busy: got %0d active cycles want 0", nbusy);
        end
        checks++;
        if (bus.hi !== hi0 || bus.lo !== lo0) begin
            errs++;
            $display("FAIL nodiv_hilo: got %h_%h want %h_%h",
                     bus.hi, bus.lo, hi0, lo0);
        end
        checks++;
        if (bus.div_zero !== 1'b0) begin
            errs++;
            $display("FAIL nodiv_dz: got %b want 0", bus.div_zero);
        end
`endif
        lat = 0;
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = OP_MTHI;
        bus.a = 32'hF0;
        @(negedge clk);
        bus.op = OP_MTLO;
        bus.a = 32'h0F;
        checks++;
        if (bus.hi !== 32'hF0) begin
            errs++;
            $display("FAIL mthi: got %h want F0", bus.hi);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errs++;
            $display("FAIL mthi_flags: got busy=%b done=%b want 0 0",
                     bus.busy, bus.done);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.lo !== 32'h0F || bus.hi !== 32'hF0) begin
            errs++;
            $display("FAIL mtlo: got hi=%h lo=%h want F0 0F", bus.hi, bus.lo);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errs++;
            $display("FAIL mtlo_flags: got busy=%b done=%b want 0 0",
                     bus.busy, bus.done);
        end
    endtask

    task automatic test_abort();
        int ndone;
        int lat;
        logic dz;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = OP_MULTU;
        bus.a = 32'd5;
        bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op = OP_DIVU;
        bus.a = 32'd1;
        bus.b = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.hi !== 32'hF0 || bus.lo !== 32'h0F) begin
            errs++;
            $display("FAIL start_while_busy: got busy=%b hi=%h lo=%h want 1 F0 0F",
                     bus.busy, bus.hi, bus.lo);
        end
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errs++;
            $display("FAIL abort_hilo: got %h_%h want 0_0", bus.hi, bus.lo);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL abort_busy: got %b want 0", bus.busy);
        end
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone !== 0) begin
            errs++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", ndone);
        end
        run_op(OP_MULTU, 32'd5, 32'd7, lat, dz);
        checks++;
        if (lat !== 33 || bus.lo !== 32'h23 || bus.hi !== 32'd0) begin
            errs++;
            $display("FAIL after_abort: got lat=%0d hi=%h lo=%h want 33 0 23",
                     lat, bus.hi, bus.lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic dz;
        bit seen;
        run_op(OP_MULTU, 32'd2, 32'd3, lat, dz);
        checks++;
        if (bus.lo !== 32'd6) begin
            errs++;
            $display("FAIL b2b_first: got %h want 6", bus.lo);
        end
        bus.start = 1'b1;
        bus.op = OP_MULTU;
        bus.a = 32'd4;
        bus.b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL b2b_accept: got busy=%b want 1", bus.busy);
        end
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus.done === 1'b1) seen = 1'b1;
            else begin
                if (bus.busy === 1'b1) lat++;
                @(negedge clk);
            end
        end
        if (!seen) lat = -1;
        checks++;
        if (lat !== 33 || bus.lo !== 32'd20 || bus.hi !== 32'd0) begin
            errs++;
            $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h want 33 0 14",
                     lat, bus.hi, bus.lo);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op = 3'b000;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_multu();
        test_mult();
`ifdef MDU_DIV_EN
        test_div();
`endif
        test_div_zero();
        test_mthi_mtlo();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
